// File: rtl/hit_inside_pkg.sv
// Shared raytracer types and helpers: Q16.16 coordinates, 3-vectors,
// the hit-test result word and the fixed-point multiply used by the
// cross-product stages.
package hit_inside_pkg;

    localparam int unsigned COORD_W    = 32;
    localparam int unsigned PROD_W     = 2 * COORD_W;
    localparam int unsigned Q_BITS_DEF = 16;
    localparam int unsigned D_BITS_DEF = 35;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef coord_t [2:0]              vec3_t;   // [0]=x, [1]=y, [2]=z

    // One output FIFO word: the untouched hit point plus its inside flag.
    typedef struct packed {
        vec3_t point;
        logic  hit;
    } result_t;

    localparam int unsigned RESULT_W = $bits(result_t);

    // Component-wise a - b, wrapping at the coordinate width.
    function automatic vec3_t vsub(input vec3_t a, input vec3_t b);
        vec3_t r;
        r[0] = $signed(a[0]) - $signed(b[0]);
        r[1] = $signed(a[1]) - $signed(b[1]);
        r[2] = $signed(a[2]) - $signed(b[2]);
        return r;
    endfunction

    // Full signed product, arithmetic-shifted back to the operand's Q format.
    function automatic logic signed [PROD_W-1:0] fx_mul(input coord_t a,
                                                        input coord_t b,
                                                        input int unsigned shift);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return p >>> shift;
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic first-word-fall-through FIFO.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   wr_en, wr_data - push (ignored when full)
//   rd_en          - pop (ignored when empty)
//   rd_data        - head word, valid whenever empty is low
//   empty, count   - occupancy status
// A write into an empty FIFO becomes visible on the following cycle; there
// is no write-to-read bypass.
module fifo #(
    parameter int unsigned WIDTH = 97,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Storage is not reset; reads are only meaningful while not empty.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hit_inside.sv
// Point-in-triangle test for ray hit points, one point per cycle.
// Each point popped from the upstream FIFO runs through a 5-stage datapath
// (edge/offset vectors, cross products, dot with the normal, sign test) and
// is pushed with its inside flag into an output FIFO.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   p_hit, in_empty         - upstream FWFT FIFO head and empty flag
//   in_rd_en                - pop the upstream FIFO at this edge
//   v0, v1, v2, tri_normal  - static triangle description (Q16.16)
//   out_point, out_hit      - output FIFO head (zero while empty)
//   out_empty, out_rd_en    - output FIFO status and pop
//   hit_count               - number of inside results written since reset
// Build option: HIT_INSIDE_EDGE_INCLUSIVE_EN makes points lying exactly on an
// edge or vertex count as inside (dk >= 0); otherwise dk > 0 is required.
module hit_inside
    import hit_inside_pkg::*;
#(
    parameter int unsigned D_BITS     = D_BITS_DEF,
    parameter int unsigned Q_BITS     = Q_BITS_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  vec3_t       p_hit,
    input  logic        in_empty,
    output logic        in_rd_en,
    input  vec3_t       v0,
    input  vec3_t       v1,
    input  vec3_t       v2,
    input  vec3_t       tri_normal,
    output vec3_t       out_point,
    output logic        out_hit,
    output logic        out_empty,
    input  logic        out_rd_en,
    output logic [31:0] hit_count
);

    localparam int unsigned N_STAGES = 5;
    localparam int unsigned M_W      = D_BITS + COORD_W;  // cross term x normal
    localparam int unsigned S_W      = M_W + 2;           // sum of three terms
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

    typedef logic signed [D_BITS-1:0] dterm_t;
    typedef logic signed [M_W-1:0]    mterm_t;
    typedef logic signed [S_W-1:0]    sterm_t;

    logic [N_STAGES-1:0] vld;
    logic                armed;
    logic [2:0]          inflight;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    vec3_t               pt [N_STAGES];
    vec3_t               s1_e [3];
    vec3_t               s1_c [3];
    logic [2:0]          pass;
    logic                s5_hit;
    result_t             wr_res;
    result_t             rd_res;

    // Admission control: a point is only taken when the FIFO can hold it
    // together with every result already in the pipeline, so nothing stalls
    // or drops. armed keeps the pop low on the first cycle after reset.
    assign inflight = 3'(vld[0]) + 3'(vld[1]) + 3'(vld[2]) + 3'(vld[3]) + 3'(vld[4]);
    assign in_rd_en = armed && !reset && !in_empty &&
                      ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));

    // Valid chain, post-reset arming and the hit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld       <= '0;
            armed     <= 1'b0;
            hit_count <= '0;
        end else begin
            vld   <= {vld[N_STAGES-2:0], in_rd_en};
            armed <= 1'b1;
            if (vld[N_STAGES-1] && s5_hit) hit_count <= hit_count + 32'd1;
        end
    end

    // Stage 1: edge vectors ek = v(k+1) - vk and offsets ck = p - vk.
    // The point itself rides alongside the datapath unchanged.
    always_ff @(posedge clock) begin
        s1_e[0] <= vsub(v1, v0);
        s1_e[1] <= vsub(v2, v1);
        s1_e[2] <= vsub(v0, v2);
        s1_c[0] <= vsub(p_hit, v0);
        s1_c[1] <= vsub(p_hit, v1);
        s1_c[2] <= vsub(p_hit, v2);
        pt[0]   <= p_hit;
        pt[1]   <= pt[0];
        pt[2]   <= pt[1];
        pt[3]   <= pt[2];
        pt[4]   <= pt[3];
    end

    // Stages 2-5 per edge: cross-product halves, difference, product with
    // the normal, then the sign of the summed dot product.
    for (genvar k = 0; k < 3; k++) begin : g_edge
        dterm_t pa [3];
        dterm_t pb [3];
        dterm_t cr [3];
        mterm_t m  [3];
        sterm_t d;

        always_ff @(posedge clock) begin
            pa[0] <= D_BITS'(fx_mul(s1_e[k][1], s1_c[k][2], Q_BITS));
            pb[0] <= D_BITS'(fx_mul(s1_e[k][2], s1_c[k][1], Q_BITS));
            pa[1] <= D_BITS'(fx_mul(s1_e[k][2], s1_c[k][0], Q_BITS));
            pb[1] <= D_BITS'(fx_mul(s1_e[k][0], s1_c[k][2], Q_BITS));
            pa[2] <= D_BITS'(fx_mul(s1_e[k][0], s1_c[k][1], Q_BITS));
            pb[2] <= D_BITS'(fx_mul(s1_e[k][1], s1_c[k][0], Q_BITS));

            cr[0] <= pa[0] - pb[0];
            cr[1] <= pa[1] - pb[1];
            cr[2] <= pa[2] - pb[2];

            // No rescale here: only the sign of the final sum matters.
            m[0] <= M_W'(cr[0]) * M_W'($signed(tri_normal[0]));
            m[1] <= M_W'(cr[1]) * M_W'($signed(tri_normal[1]));
            m[2] <= M_W'(cr[2]) * M_W'($signed(tri_normal[2]));
        end

        assign d = S_W'(m[0]) + S_W'(m[1]) + S_W'(m[2]);

`ifdef HIT_INSIDE_EDGE_INCLUSIVE_EN
        assign pass[k] = !d[S_W-1];
`else
        assign pass[k] = !d[S_W-1] && (d != '0);
`endif
    end

    // Stage 5 register: inside only if all three edges agree.
    always_ff @(posedge clock) begin
        s5_hit <= &pass;
    end

    assign wr_res = '{point: pt[N_STAGES-1], hit: s5_hit};

    fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (vld[N_STAGES-1]),
        .wr_data (wr_res),
        .rd_en   (out_rd_en),
        .rd_data (rd_res),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Stale storage is hidden while the FIFO is empty.
    assign out_empty = fifo_empty;
    assign out_point = fifo_empty ? '0 : rd_res.point;
    assign out_hit   = !fifo_empty && rd_res.hit;

endmodule

// File: tb/tb_hit_inside.sv
// Bench for hit_inside: directed table of known points on the unit
// triangle, latency, backpressure and mid-stream reset sequences, then
// randomized streams scored against an arithmetic reference model.
module tb_hit_inside;
    import hit_inside_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef HIT_INSIDE_EDGE_INCLUSIVE_EN
    localparam bit INCL = 1'b1;
`else
    localparam bit INCL = 1'b0;
`endif
    localparam int ONE = 32'h10000;

    logic        clock;
    logic        reset;
    vec3_t       p_hit;
    logic        in_empty;
    logic        in_rd_en;
    vec3_t       v0, v1, v2, tri_normal;
    vec3_t       out_point;
    logic        out_hit;
    logic        out_empty;
    logic        out_rd_en;
    logic [31:0] hit_count;

    hit_inside #(
        .D_BITS     (D_BITS_DEF),
        .Q_BITS     (Q_BITS_DEF),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .p_hit      (p_hit),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .v0         (v0),
        .v1         (v1),
        .v2         (v2),
        .tri_normal (tri_normal),
        .out_point  (out_point),
        .out_hit    (out_hit),
        .out_empty  (out_empty),
        .out_rd_en  (out_rd_en),
        .hit_count  (hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        vec3_t pt;
        bit    hit;
    } exp_t;

    typedef struct {
        string name;
        vec3_t p;
        bit    hit;
    } row_t;

    vec3_t       src_q[$];
    exp_t        exp_q[$];
    int unsigned model_hits;
    int unsigned pops;
    int          tests;
    int          fails;

    function automatic vec3_t mk(input int x, input int y, input int z);
        vec3_t r;
        r[0] = coord_t'(x);
        r[1] = coord_t'(y);
        r[2] = coord_t'(z);
        return r;
    endfunction

    function automatic coord_t rnd_c(input int lo, input int hi);
        int r;
        r = lo + int'($urandom_range(0, hi - lo));
        return coord_t'(r);
    endfunction

    // Reference: sign of (ek x ck) . n for every edge, with products
    // floored back to Q16.16 before the cross-product subtraction.
    function automatic bit model_hit(input vec3_t p, input vec3_t a, input vec3_t b,
                                     input vec3_t c, input vec3_t n);
        longint vt[3][3];
        longint pp[3], nn[3], e[3], cc[3], x[3], d;
        bit     all_in;
        all_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vt[0][i] = longint'($signed(a[i]));
            vt[1][i] = longint'($signed(b[i]));
            vt[2][i] = longint'($signed(c[i]));
            pp[i]    = longint'($signed(p[i]));
            nn[i]    = longint'($signed(n[i]));
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                e[i]  = vt[(k + 1) % 3][i] - vt[k][i];
                cc[i] = pp[i] - vt[k][i];
            end
            for (int i = 0; i < 3; i++)
                x[i] = ((e[(i + 1) % 3] * cc[(i + 2) % 3]) >>> Q_BITS_DEF)
                     - ((e[(i + 2) % 3] * cc[(i + 1) % 3]) >>> Q_BITS_DEF);
            d = x[0] * nn[0] + x[1] * nn[1] + x[2] * nn[2];
            if (INCL ? (d < 0) : (d <= 0)) all_in = 1'b0;
        end
        return all_in;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() > 0) begin
            p_hit    = src_q[0];
            in_empty = 1'b0;
        end else begin
            p_hit    = '0;
            in_empty = 1'b1;
        end
    endtask

    // One clock: sample handshakes at the falling edge, score any output
    // pop, then after the rising edge retire the upstream pop into the model.
    task automatic tick(output bit rd);
        bit   pop;
        exp_t e;
        vec3_t pt;
        @(negedge clock);
        rd  = in_rd_en;
        pop = out_rd_en && !out_empty;
        if (pop) begin
            pops++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got point %0h with no result pending", out_point);
            end else begin
                e = exp_q.pop_front();
                chk("out_point", 128'(out_point), 128'(e.pt));
                chk("out_hit", 128'(out_hit), 128'(e.hit));
            end
        end
        @(posedge clock);
        #1;
        if (rd) begin
            if (src_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_on_empty: in_rd_en got 1 expected 0");
            end else begin
                pt    = src_q.pop_front();
                e.pt  = pt;
                e.hit = model_hit(pt, v0, v1, v2, tri_normal);
                exp_q.push_back(e);
                if (e.hit) model_hits++;
            end
        end
        drive_src();
    endtask

    task automatic tick1();
        bit d;
        tick(d);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            chk("rd_en_in_reset", 128'(in_rd_en), 128'(0));
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        exp_q.delete();
        model_hits = 0;
        @(negedge clock);
        chk("rd_en_after_reset", 128'(in_rd_en), 128'(0));
        chk("rst_out_empty", 128'(out_empty), 128'(1));
        chk("rst_out_point", 128'(out_point), 128'(0));
        chk("rst_out_hit", 128'(out_hit), 128'(0));
        chk("rst_hit_count", 128'(hit_count), 128'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (out_empty && n < 20) begin
            tick1();
            n++;
        end
        if (out_empty) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: out_empty got 1 expected 0 within 20 cycles", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t        rows[8];
        bit          rd;
        int          reads;
        int unsigned exp_cnt;
        int unsigned pops0;
        int          n;
        int          sent;
        vec3_t       pd;

        rows[0] = '{"hit",      mk(32'h4000, 32'h4000, 0),       1'b1};
        rows[1] = '{"miss",     mk(ONE, ONE, 0),                 1'b0};
        rows[2] = '{"edge",     mk(32'h8000, 0, 0),              INCL};
        rows[3] = '{"vertex",   mk(0, 0, 0),                     INCL};
        rows[4] = '{"interior", mk(32'h5000, 32'h2000, 0),       1'b1};
        rows[5] = '{"outside",  mk(-32'sh1000, 32'h4000, 0),     1'b0};
        rows[6] = '{"hypot",    mk(32'h8000, 32'h8000, 0),       INCL};
        rows[7] = '{"above",    mk(32'h4000, 32'h4000, 2 * ONE), 1'b1};

        tests      = 0;
        fails      = 0;
        pops       = 0;
        model_hits = 0;
        reset      = 1'b1;
        out_rd_en  = 1'b0;
        v0         = mk(0, 0, 0);
        v1         = mk(ONE, 0, 0);
        v2         = mk(0, ONE, 0);
        tri_normal = mk(0, 0, ONE);

        // Reset with a point already waiting upstream.
        src_q.push_back(rows[0].p);
        drive_src();
        do_reset(2);

        // Latency: read at edge N, result visible only after edge N+5.
        tick(rd);
        chk("rd_en_armed", 128'(rd), 128'(1));
        for (int j = 1; j <= 5; j++) begin
            tick1();
            if (j == 4) chk("lat_still_empty", 128'(out_empty), 128'(1));
            if (j == 5) chk("lat_ready", 128'(out_empty), 128'(0));
        end
        chk("hit_point", 128'(out_point), 128'(rows[0].p));
        chk("hit_flag", 128'(out_hit), 128'(1));
        chk("hit_count_1", 128'(hit_count), 128'(1));
        out_rd_en = 1'b1;
        tick1();
        out_rd_en = 1'b0;
        exp_cnt = 1;

        // Directed table on the unit triangle.
        for (int r = 1; r < 8; r++) begin
            src_q.push_back(rows[r].p);
            drive_src();
            wait_out(rows[r].name);
            if (rows[r].hit) exp_cnt++;
            chk({rows[r].name, "_point"}, 128'(out_point), 128'(rows[r].p));
            chk({rows[r].name, "_hit"}, 128'(out_hit), 128'(rows[r].hit));
            chk({rows[r].name, "_count"}, 128'(hit_count), 128'(exp_cnt));
            out_rd_en = 1'b1;
            tick1();
            out_rd_en = 1'b0;
        end

        // Mid-stream reset with three results buffered.
        src_q.push_back(rows[0].p);
        src_q.push_back(rows[4].p);
        src_q.push_back(rows[1].p);
        drive_src();
        repeat (12) tick1();
        chk("buffered_not_empty", 128'(out_empty), 128'(0));
        pd = mk(32'h3000, 32'h2000, 0);
        src_q.push_back(pd);
        drive_src();
        do_reset(1);
        wait_out("post_reset");
        chk("post_reset_point", 128'(out_point), 128'(pd));
        chk("post_reset_hit", 128'(out_hit), 128'(1));
        chk("post_reset_count", 128'(hit_count), 128'(1));
        out_rd_en = 1'b1;
        tick1();
        out_rd_en = 1'b0;

        // Backpressure: output held, only DEPTH points may be admitted.
        for (int i = 0; i < 10; i++)
            src_q.push_back(mk(rnd_c(-32'sh8000, 32'h18000), rnd_c(-32'sh8000, 32'h18000), 0));
        drive_src();
        reads = 0;
        repeat (30) begin
            tick(rd);
            if (rd) reads++;
        end
        chk("bp_reads", 128'(reads), 128'(DEPTH));
        chk("bp_rd_en_low", 128'(in_rd_en), 128'(0));
        chk("bp_src_left", 128'(src_q.size()), 128'(10 - DEPTH));
        pops0 = pops;
        out_rd_en = 1'b1;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            tick1();
            n++;
        end
        out_rd_en = 1'b0;
        chk("bp_all_out", 128'(pops - pops0), 128'(10));

        // Randomized streams: unit triangle, then arbitrary triangles/normals.
        for (int round = 0; round < 3; round++) begin
            if (round > 0) begin
                v0         = mk(rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000));
                v1         = mk(rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000));
                v2         = mk(rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000));
                tri_normal = mk(rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000));
            end
            sent = 0;
            n    = 0;
            while ((sent < 100 || src_q.size() > 0 || exp_q.size() > 0) && n < 1500) begin
                if (sent < 100 && $urandom_range(0, 1) == 1) begin
                    if (round == 0)
                        src_q.push_back(mk(rnd_c(-32'sh8000, 32'h18000), rnd_c(-32'sh8000, 32'h18000), rnd_c(-32'sh8000, 32'h8000)));
                    else
                        src_q.push_back(mk(rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000), rnd_c(-32'sh40000, 32'h40000)));
                    sent++;
                    drive_src();
                end
                out_rd_en = ($urandom_range(0, 3) != 0);
                tick1();
                n++;
            end
            out_rd_en = 1'b0;
            chk("rand_drained", 128'(exp_q.size() + src_q.size()), 128'(0));
            chk("rand_hit_count", 128'(hit_count), 128'(model_hits));
            chk("rand_out_empty", 128'(out_empty), 128'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
